// File: rtl/reg_pipe_if.sv
// Handshake bundle for reg_pipe: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// The flush signal exists only when REG_PIPE_FLUSH_EN is defined.
interface reg_pipe_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] count;
`ifdef REG_PIPE_FLUSH_EN
   logic             flush;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data, count
   );
   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, count
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
`endif
endinterface

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipe with per-stage backpressure and an occupancy count.
// Optional REG_PIPE_FLUSH_EN adds a synchronous flush that empties every stage.
module reg_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input logic      clk,
   input logic      rst,
   reg_pipe_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_vec;
   logic [WIDTH-1:0] d_vec [DEPTH];
   logic [DEPTH:0]   rdy;
   logic             flush_w;
   logic             accept;
   logic             deliver;
   logic [CNT_W-1:0] count_reg;

`ifdef REG_PIPE_FLUSH_EN
   assign flush_w = bus.flush;
`else
   assign flush_w = 1'b0;
`endif

   // A stage may load when it is empty or its occupant moves on this cycle.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = bus.out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         rdy[k] = !v_vec[k] | rdy[k+1];
      end
   end

   assign bus.in_ready  = rdy[0] & !flush_w;
   assign bus.out_valid = v_vec[DEPTH-1];
   assign bus.out_data  = d_vec[DEPTH-1];
   assign bus.count     = count_reg;

   assign accept  = bus.in_valid & bus.in_ready;
   assign deliver = v_vec[DEPTH-1] & bus.out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             src_v;
         logic [WIDTH-1:0] src_d;
         logic             v_reg;
         logic [WIDTH-1:0] d_reg;

         if (gi == 0) begin : g_head
            assign src_v = bus.in_valid;
            assign src_d = bus.in_data;
         end else begin : g_body
            assign src_v = v_vec[gi-1];
            assign src_d = d_vec[gi-1];
         end

         // Data only loads with a real word, so bubbles leave d_reg untouched.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_reg <= 1'b0;
               d_reg <= '0;
            end else if (flush_w) begin
               v_reg <= 1'b0;
            end else if (rdy[gi]) begin
               v_reg <= src_v;
               if (src_v) begin
                  d_reg <= src_d;
               end
            end
         end

         assign v_vec[gi] = v_reg;
         assign d_vec[gi] = d_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (flush_w) begin
         count_reg <= '0;
      end else if (accept && !deliver) begin
         count_reg <= count_reg + 1'b1;
      end else if (deliver && !accept) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (count_reg <= CNT_W'(DEPTH));
         assert (count_reg == CNT_W'($countones(v_vec)));
      end
   end
endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: randomized traffic against a queue model of word positions.
// Build with REG_PIPE_FLUSH_EN defined to also exercise the flush scenario.
module tb_reg_pipe;
   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   bit   cur_fl = 1'b0;

   // Model: words in acceptance order, each with the stage index it occupies.
   logic [WIDTH-1:0] m_data [$];
   int               m_pos  [$];

   reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Words slide forward as far as the word ahead (after its own move) allows.
   function automatic bit m_ready(bit ordy);
      int lim = DEPTH - 1;
      int first = 0;
      int np;
      if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1 && ordy) first = 1;
      for (int i = first; i < m_pos.size(); i++) begin
         np  = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
         lim = np - 1;
      end
      return lim >= 0;
   endfunction

   function automatic bit e_valid();
      return m_pos.size() > 0 && m_pos[0] == DEPTH - 1;
   endfunction

   function automatic bit e_ready();
      return !cur_fl && m_ready(bus.out_ready);
   endfunction

   task automatic m_advance(bit iv, logic [WIDTH-1:0] din, bit ordy, bit fl);
      bit acc;
      int lim;
      int np;
      acc = iv && !fl && m_ready(ordy);
      if (fl) begin
         m_data.delete();
         m_pos.delete();
         return;
      end
      if (e_valid() && ordy) begin
         void'(m_data.pop_front());
         void'(m_pos.pop_front());
      end
      lim = DEPTH - 1;
      foreach (m_pos[i]) begin
         np = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
         m_pos[i] = np;
         lim = np - 1;
      end
      if (acc) begin
         m_data.push_back(din);
         m_pos.push_back(0);
      end
   endtask

   task automatic drive(input bit iv, input logic [WIDTH-1:0] din, input bit ordy, input bit fl);
      bus.in_valid  = iv;
      bus.in_data   = din;
      bus.out_ready = ordy;
`ifdef REG_PIPE_FLUSH_EN
      bus.flush     = fl;
`endif
      cur_fl = fl;
      #1;
   endtask

   task automatic tick();
      if (e_valid() && bus.out_ready) $display("cycle %0d: deliver %02h", cyc, m_data[0]);
      if (bus.in_valid && e_ready()) $display("cycle %0d: accept %02h", cyc, bus.in_data);
      m_advance(bus.in_valid, bus.in_data, bus.out_ready, cur_fl);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH && m_pos.size() > 0; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got=%02h want=00", bus.out_data); else n_pass++;
      n_checks++; if (bus.count !== 2'd0) $display("FAIL reset_count got=%0d want=0", bus.count); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_or0 got=%b want=1", bus.in_ready); else n_pass++;
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_or1 got=%b want=1", bus.in_ready); else n_pass++;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_streaming();
      int sent = 0;
      int got = 0;
      int first_acc = -1;
      int first_val = -1;
      for (int g = 0; g < 2000 && got < 256; g++) begin
         drive(sent < 256, sent[7:0], 1'b1, 1'b0);
         n_checks++; if (bus.in_ready !== e_ready()) $display("FAIL stream_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, e_ready()); else n_pass++;
         n_checks++; if (bus.out_valid !== e_valid()) $display("FAIL stream_out_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid, e_valid()); else n_pass++;
         n_checks++; if (bus.count !== CNT_W'(m_pos.size())) $display("FAIL stream_count cyc=%0d got=%0d want=%0d", cyc, bus.count, m_pos.size()); else n_pass++;
         if (e_valid()) begin
            n_checks++; if (bus.out_data !== got[7:0]) $display("FAIL stream_data cyc=%0d got=%02h want=%02h", cyc, bus.out_data, got[7:0]); else n_pass++;
            got++;
         end
         if (bus.out_valid === 1'b1 && first_val < 0) first_val = cyc;
         if (bus.in_valid && e_ready()) begin
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end
         tick();
      end
      n_checks++; if (got != 256) $display("FAIL stream_total got=%0d want=256", got); else n_pass++;
      n_checks++; if (first_val != first_acc + DEPTH) $display("FAIL stream_latency got=%0d want=%0d", first_val - first_acc, DEPTH); else n_pass++;
   endtask

   task automatic test_backpressure();
      int nxt = 0;
      int exp_out = 0;
      logic [WIDTH-1:0] held;
      for (int c = 0; c < 30; c++) begin
         bit stall;
         stall = (c >= 5 && c < 11);
         drive(c < 14, nxt[7:0], !stall, 1'b0);
         if (c == 5) held = bus.out_data;
         if (stall) begin
            n_checks++; if (bus.out_data !== held) $display("FAIL bp_hold cyc=%0d got=%02h want=%02h", cyc, bus.out_data, held); else n_pass++;
         end
         if (c == 10) begin
            n_checks++; if (bus.count !== 2'd3) $display("FAIL bp_full_count got=%0d want=3", bus.count); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b want=0", bus.in_ready); else n_pass++;
         end
         n_checks++; if (bus.out_valid !== e_valid()) $display("FAIL bp_out_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid, e_valid()); else n_pass++;
         if (e_valid() && !stall) begin
            n_checks++; if (bus.out_data !== exp_out[7:0]) $display("FAIL bp_seq cyc=%0d got=%02h want=%02h", cyc, bus.out_data, exp_out[7:0]); else n_pass++;
            exp_out++;
         end
         if (bus.in_valid && e_ready()) nxt++;
         tick();
      end
      n_checks++; if (exp_out != nxt) $display("FAIL bp_total got=%0d want=%0d", exp_out, nxt); else n_pass++;
   endtask

   task automatic test_bubbles();
      int sent = 0;
      int got = 0;
      for (int k = 0; k < 5000 && got < 300; k++) begin
         bit iv;
         iv = (sent < 300) && ((k % 4 == 0) || (k % 4 == 3));
         drive(iv, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         n_checks++; if (bus.in_ready !== e_ready()) $display("FAIL bub_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, e_ready()); else n_pass++;
         n_checks++; if (bus.out_valid !== e_valid()) $display("FAIL bub_out_valid cyc=%0d got=%b want=%b", cyc, bus.out_valid, e_valid()); else n_pass++;
         n_checks++; if (bus.count !== CNT_W'(m_pos.size())) $display("FAIL bub_count cyc=%0d got=%0d want=%0d", cyc, bus.count, m_pos.size()); else n_pass++;
         if (e_valid()) begin
            n_checks++; if (bus.out_data !== m_data[0]) $display("FAIL bub_data cyc=%0d got=%02h want=%02h", cyc, bus.out_data, m_data[0]); else n_pass++;
            if (bus.out_ready) got++;
         end
         if (bus.in_valid && e_ready()) sent++;
         tick();
      end
      n_checks++; if (got != 300) $display("FAIL bub_total got=%0d want=300", got); else n_pass++;
   endtask

   task automatic test_full_simultaneous();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, WIDTH'(8'h50 + i), 1'b1, 1'b0);
         n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL full_in_ready i=%0d got=%b want=1", i, bus.in_ready); else n_pass++;
         n_checks++; if (bus.count !== 2'd3) $display("FAIL full_count i=%0d got=%0d want=3", i, bus.count); else n_pass++;
         n_checks++; if (bus.out_data !== m_data[0]) $display("FAIL full_data i=%0d got=%02h want=%02h", i, bus.out_data, m_data[0]); else n_pass++;
         tick();
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      int acc_cyc = -1;
      int seen_cyc = -1;
      int n_out = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_checks++; if (bus.count !== 2'd2) $display("FAIL mid_pre_count got=%0d want=2", bus.count); else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_data !== 8'h00) $display("FAIL mid_rst_out_data got=%02h want=00", bus.out_data); else n_pass++;
      n_checks++; if (bus.count !== 2'd0) $display("FAIL mid_rst_count got=%0d want=0", bus.count); else n_pass++;
      m_data.delete();
      m_pos.delete();
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         drive(i == 0, 8'hA5, 1'b1, 1'b0);
         if (i == 0 && e_ready()) acc_cyc = cyc;
         if (bus.out_valid === 1'b1) begin
            n_out++;
            if (seen_cyc < 0) seen_cyc = cyc;
            n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL mid_word got=%02h want=a5", bus.out_data); else n_pass++;
         end
         tick();
      end
      n_checks++; if (n_out != 1) $display("FAIL mid_word_count got=%0d want=1", n_out); else n_pass++;
      n_checks++; if (seen_cyc != acc_cyc + DEPTH) $display("FAIL mid_latency got=%0d want=%0d", seen_cyc - acc_cyc, DEPTH); else n_pass++;
   endtask

`ifdef REG_PIPE_FLUSH_EN
   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, WIDTH'(8'h70 + i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'hEE, 1'b1, 1'b1);
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b want=0", bus.in_ready); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_out_valid_during got=%b want=1", bus.out_valid); else n_pass++;
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid i=%0d got=%b want=0", i, bus.out_valid); else n_pass++;
         n_checks++; if (bus.count !== 2'd0) $display("FAIL flush_count i=%0d got=%0d want=0", i, bus.count); else n_pass++;
         tick();
      end
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
      bus.flush     = 1'b0;
`endif
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubbles();
      test_full_simultaneous();
      test_reset_midstream();
`ifdef REG_PIPE_FLUSH_EN
      test_flush();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
